// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants and conversion/validation helpers
package bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_MAX_DIGITS = 16;
  localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'd9;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ZERO = 4'd0;

  function automatic logic [BCD_DIGIT_W*BCD_MAX_DIGITS-1:0] bin_to_bcd(input int value, input int digits);
    logic [BCD_DIGIT_W*BCD_MAX_DIGITS-1:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < BCD_MAX_DIGITS; i++)
      if (i < digits) begin
        r[BCD_DIGIT_W*i +: BCD_DIGIT_W] = 4'(v % 10);
        v = v / 10;
      end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [BCD_DIGIT_W*BCD_MAX_DIGITS-1:0] vec, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++)
      if (i < digits && vec[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_NINE) ok = 1'b0;
    return ok;
  endfunction
endpackage

// File: rtl/bcd_modulo_counter_if.sv
// bcd_modulo_counter_if: control/status bundle of one counter stage (wrap flag pins with BCD_MODULO_COUNTER_WRAP_FLAG_EN)
interface bcd_modulo_counter_if #(parameter int DIGITS = 2);
  logic enable;
  logic up;
  logic load;
  logic [4*DIGITS-1:0] load_value;
  logic [4*DIGITS-1:0] count;
  logic max;
  logic min;
  logic carry;
  logic load_err;
`ifdef BCD_MODULO_COUNTER_WRAP_FLAG_EN
  logic wrap_clear;
  logic wrap_flag;
  modport master(output enable, up, load, load_value, wrap_clear, input count, max, min, carry, load_err, wrap_flag);
  modport slave(input enable, up, load, load_value, wrap_clear, output count, max, min, carry, load_err, wrap_flag);
`else
  modport master(output enable, up, load, load_value, input count, max, min, carry, load_err);
  modport slave(input enable, up, load, load_value, output count, max, min, carry, load_err);
`endif
endinterface

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD decade that loads, steps up/down and flags its 9/0 terminal states
module bcd_digit
  import bcd_pkg::*;
#(
  parameter logic [BCD_DIGIT_W-1:0] RESET_DIGIT = BCD_ZERO
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ld,
  input  logic [BCD_DIGIT_W-1:0] ld_digit,
  input  logic                   step,
  input  logic                   up,
  output logic [BCD_DIGIT_W-1:0] digit,
  output logic                   at_nine,
  output logic                   at_zero
);
  assign at_nine = digit == BCD_NINE;
  assign at_zero = digit == BCD_ZERO;

  // Load has priority; a step wraps 9->0 going up and 0->9 going down.
  always_ff @(posedge clock or negedge reset)
    if (!reset) digit <= RESET_DIGIT;
    else if (ld) digit <= ld_digit;
    else if (step) digit <= up ? (at_nine ? BCD_ZERO : digit + 4'd1) : (at_zero ? BCD_NINE : digit - 4'd1);
endmodule

// File: rtl/bcd_modulo_counter.sv
// bcd_modulo_counter: cascadable BCD counter modulo MODULUS; BCD_MODULO_COUNTER_WRAP_FLAG_EN adds a sticky wrap flag
module bcd_modulo_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int MODULUS     = 60,
  parameter int RESET_VALUE = 0
) (
  input logic               clock,
  input logic               reset,
  bcd_modulo_counter_if.slave bus
);
  localparam int W = BCD_DIGIT_W * DIGITS;
  localparam logic [BCD_DIGIT_W*BCD_MAX_DIGITS-1:0] MAX_FULL = bin_to_bcd(MODULUS - 1, DIGITS);
  localparam logic [BCD_DIGIT_W*BCD_MAX_DIGITS-1:0] RST_FULL = bin_to_bcd(RESET_VALUE, DIGITS);
  localparam logic [W-1:0] MAX_BCD = MAX_FULL[W-1:0];
  localparam logic [W-1:0] RST_BCD = RST_FULL[W-1:0];

  if (MODULUS < 2 || MODULUS > 10 ** DIGITS) begin : g_bad_modulus
    $error("bcd_modulo_counter: MODULUS out of range 2..10^DIGITS");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
    $error("bcd_modulo_counter: RESET_VALUE must be below MODULUS");
  end

  logic [W-1:0]      count;
  logic [W-1:0]      ld_val;
  logic [DIGITS-1:0] nine;
  logic [DIGITS-1:0] zero;
  logic [DIGITS-1:0] match;
  logic [DIGITS-1:0] chain;
  logic              step_en;
  logic              wrap_cond;
  logic              load_ok;
  logic              ld;

  // BCD order matches numeric order, so "< MODULUS" is "<= MAX_BCD" on valid digits.
  assign load_ok   = bus.load & bcd_valid(64'(bus.load_value), DIGITS) & (bus.load_value <= MAX_BCD);
  assign step_en   = bus.enable & ~bus.load;
  assign wrap_cond = bus.up ? bus.max : bus.min;
  assign bus.carry = step_en & wrap_cond;
  assign ld        = load_ok | bus.carry;
  assign ld_val    = bus.load ? bus.load_value : (bus.up ? '0 : MAX_BCD);
  assign chain[0]  = step_en & ~wrap_cond;
  assign bus.count = count;
  assign bus.max   = &match;
  assign bus.min   = &zero;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    localparam logic [BCD_DIGIT_W-1:0] MD = MAX_BCD[BCD_DIGIT_W*g +: BCD_DIGIT_W];
    assign match[g] = (MD == BCD_NINE) ? nine[g] : (count[BCD_DIGIT_W*g +: BCD_DIGIT_W] == MD);
    if (g > 0) begin : g_ripple
      assign chain[g] = chain[g-1] & (bus.up ? nine[g-1] : zero[g-1]);
    end
    bcd_digit #(.RESET_DIGIT(RST_BCD[BCD_DIGIT_W*g +: BCD_DIGIT_W])) u_digit (
      .clock    (clock),
      .reset    (reset),
      .ld       (ld),
      .ld_digit (ld_val[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .step     (chain[g]),
      .up       (bus.up),
      .digit    (count[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .at_nine  (nine[g]),
      .at_zero  (zero[g])
    );
  end

  // Pulse load_err for one cycle on every rejected load.
  always_ff @(posedge clock or negedge reset)
    if (!reset) bus.load_err <= 1'b0;
    else bus.load_err <= bus.load & ~load_ok;

`ifdef BCD_MODULO_COUNTER_WRAP_FLAG_EN
  // Sticky wrap record; a new wrap beats a simultaneous clear.
  always_ff @(posedge clock or negedge reset)
    if (!reset) bus.wrap_flag <= 1'b0;
    else if (bus.carry) bus.wrap_flag <= 1'b1;
    else if (bus.wrap_clear) bus.wrap_flag <= 1'b0;
`endif
endmodule

// File: tb/tb_bcd_modulo_counter.sv
// tb_bcd_modulo_counter: directed checks of wrap, load rules, reset and a secs/mins/hours cascade
module tb_bcd_modulo_counter;
  logic clock = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  bcd_modulo_counter_if #(.DIGITS(2)) i60 ();
  bcd_modulo_counter_if #(.DIGITS(2)) i24 ();
  bcd_modulo_counter_if #(.DIGITS(2)) is ();
  bcd_modulo_counter_if #(.DIGITS(2)) im ();
  bcd_modulo_counter_if #(.DIGITS(2)) ih ();

  assign im.enable = is.carry;
  assign ih.enable = im.carry;

  bcd_modulo_counter #(.DIGITS(2), .MODULUS(60), .RESET_VALUE(0))  u60 (.clock(clock), .reset(reset), .bus(i60));
  bcd_modulo_counter #(.DIGITS(2), .MODULUS(24), .RESET_VALUE(13)) u24 (.clock(clock), .reset(reset), .bus(i24));
  bcd_modulo_counter #(.DIGITS(2), .MODULUS(60), .RESET_VALUE(0))  us  (.clock(clock), .reset(reset), .bus(is));
  bcd_modulo_counter #(.DIGITS(2), .MODULUS(60), .RESET_VALUE(0))  um  (.clock(clock), .reset(reset), .bus(im));
  bcd_modulo_counter #(.DIGITS(2), .MODULUS(24), .RESET_VALUE(0))  uh  (.clock(clock), .reset(reset), .bus(ih));

  task automatic load60(input logic [7:0] v);
    @(negedge clock);
    i60.load = 1'b1; i60.load_value = v;
    @(negedge clock);
    i60.load = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++; if (i60.count !== 8'h00) begin n_err++; $display("FAIL rst_cnt60 got %h want 00", i60.count); end
    n_cmp++; if (i24.count !== 8'h13) begin n_err++; $display("FAIL rst_cnt24 got %h want 13", i24.count); end
    n_cmp++; if (i60.load_err !== 1'b0) begin n_err++; $display("FAIL rst_lerr got %b want 0", i60.load_err); end
    n_cmp++; if (i60.min !== 1'b1) begin n_err++; $display("FAIL rst_min got %b want 1", i60.min); end
    load60(8'h37);
    n_cmp++; if (i60.count !== 8'h37) begin n_err++; $display("FAIL pre_rst_cnt got %h want 37", i60.count); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (i60.count !== 8'h00) begin n_err++; $display("FAIL async_rst_cnt got %h want 00", i60.count); end
    n_cmp++; if (i60.load_err !== 1'b0) begin n_err++; $display("FAIL async_rst_lerr got %b want 0", i60.load_err); end
    #1 reset = 1'b1;
  endtask

  task automatic test_up_wrap;
    int carries = 0;
    load60(8'h58);
    i60.enable = 1'b1; i60.up = 1'b1;
    #1;
    n_cmp++; if (i60.count !== 8'h58) begin n_err++; $display("FAIL up_start got %h want 58", i60.count); end
    carries += int'(i60.carry);
    @(negedge clock);
    n_cmp++; if (i60.count !== 8'h59) begin n_err++; $display("FAIL up_59 got %h want 59", i60.count); end
    n_cmp++; if (i60.max !== 1'b1) begin n_err++; $display("FAIL up_max got %b want 1", i60.max); end
    n_cmp++; if (i60.carry !== 1'b1) begin n_err++; $display("FAIL up_carry got %b want 1", i60.carry); end
    carries += int'(i60.carry);
    @(negedge clock);
    n_cmp++; if (i60.count !== 8'h00) begin n_err++; $display("FAIL up_wrap got %h want 00", i60.count); end
    carries += int'(i60.carry);
    i60.enable = 1'b0;
    n_cmp++; if (carries !== 1) begin n_err++; $display("FAIL up_carry_cnt got %0d want 1", carries); end
  endtask

  task automatic test_down_wrap;
    @(negedge clock);
    i24.load = 1'b1; i24.load_value = 8'h01;
    @(negedge clock);
    i24.load = 1'b0; i24.enable = 1'b1; i24.up = 1'b0;
    #1;
    n_cmp++; if (i24.count !== 8'h01) begin n_err++; $display("FAIL dn_start got %h want 01", i24.count); end
    n_cmp++; if (i24.carry !== 1'b0) begin n_err++; $display("FAIL dn_nocarry got %b want 0", i24.carry); end
    @(negedge clock);
    n_cmp++; if (i24.count !== 8'h00) begin n_err++; $display("FAIL dn_00 got %h want 00", i24.count); end
    n_cmp++; if ({i24.min, i24.max, i24.carry} !== 3'b101) begin n_err++; $display("FAIL dn_flags got %b want 101", {i24.min, i24.max, i24.carry}); end
    @(negedge clock);
    n_cmp++; if (i24.count !== 8'h23) begin n_err++; $display("FAIL dn_wrap got %h want 23", i24.count); end
    n_cmp++; if (i24.max !== 1'b1) begin n_err++; $display("FAIL dn_max got %b want 1", i24.max); end
    @(negedge clock);
    n_cmp++; if (i24.count !== 8'h22) begin n_err++; $display("FAIL dn_22 got %h want 22", i24.count); end
    i24.up = 1'b1;
    @(negedge clock);
    n_cmp++; if (i24.count !== 8'h23) begin n_err++; $display("FAIL dir_turn got %h want 23", i24.count); end
    i24.enable = 1'b0;
  endtask

  task automatic test_load_rules;
    load60(8'h5A);
    n_cmp++; if (i60.count !== 8'h00) begin n_err++; $display("FAIL ld5a_hold got %h want 00", i60.count); end
    n_cmp++; if (i60.load_err !== 1'b1) begin n_err++; $display("FAIL ld5a_err got %b want 1", i60.load_err); end
    @(negedge clock);
    n_cmp++; if (i60.load_err !== 1'b0) begin n_err++; $display("FAIL ld5a_pulse got %b want 0", i60.load_err); end
    load60(8'h60);
    n_cmp++; if (i60.count !== 8'h00) begin n_err++; $display("FAIL ld60_hold got %h want 00", i60.count); end
    n_cmp++; if (i60.load_err !== 1'b1) begin n_err++; $display("FAIL ld60_err got %b want 1", i60.load_err); end
    @(negedge clock);
    i60.load = 1'b1; i60.load_value = 8'h42; i60.enable = 1'b1; i60.up = 1'b1;
    #1;
    n_cmp++; if (i60.carry !== 1'b0) begin n_err++; $display("FAIL ld42_carry got %b want 0", i60.carry); end
    @(negedge clock);
    i60.load = 1'b0; i60.enable = 1'b0;
    n_cmp++; if (i60.count !== 8'h42) begin n_err++; $display("FAIL ld42_cnt got %h want 42", i60.count); end
    n_cmp++; if (i60.load_err !== 1'b0) begin n_err++; $display("FAIL ld42_err got %b want 0", i60.load_err); end
    load60(8'h59);
    n_cmp++; if (i60.count !== 8'h59) begin n_err++; $display("FAIL ld59_cnt got %h want 59", i60.count); end
    @(negedge clock);
    n_cmp++; if (i60.count !== 8'h59) begin n_err++; $display("FAIL hold got %h want 59", i60.count); end
  endtask

  task automatic test_cascade;
    @(negedge clock);
    is.load = 1'b1; is.load_value = 8'h59;
    im.load = 1'b1; im.load_value = 8'h59;
    ih.load = 1'b1; ih.load_value = 8'h23;
    @(negedge clock);
    is.load = 1'b0; im.load = 1'b0; ih.load = 1'b0;
    is.enable = 1'b1;
    #1;
    n_cmp++; if ({ih.count, im.count, is.count} !== 24'h235959) begin n_err++; $display("FAIL casc_start got %h want 235959", {ih.count, im.count, is.count}); end
    n_cmp++; if ({is.carry, im.carry, ih.carry} !== 3'b111) begin n_err++; $display("FAIL casc_carry got %b want 111", {is.carry, im.carry, ih.carry}); end
    @(negedge clock);
    n_cmp++; if ({ih.count, im.count, is.count} !== 24'h000000) begin n_err++; $display("FAIL casc_wrap got %h want 000000", {ih.count, im.count, is.count}); end
    n_cmp++; if (im.carry !== 1'b0) begin n_err++; $display("FAIL casc_mcarry got %b want 0", im.carry); end
    @(negedge clock);
    is.enable = 1'b0;
    n_cmp++; if ({ih.count, im.count, is.count} !== 24'h000001) begin n_err++; $display("FAIL casc_next got %h want 000001", {ih.count, im.count, is.count}); end
  endtask

`ifdef BCD_MODULO_COUNTER_WRAP_FLAG_EN
  task automatic test_wrap_flag;
    @(negedge clock);
    i60.wrap_clear = 1'b1;
    @(negedge clock);
    i60.wrap_clear = 1'b0;
    n_cmp++; if (i60.wrap_flag !== 1'b0) begin n_err++; $display("FAIL wf_clear got %b want 0", i60.wrap_flag); end
    load60(8'h59);
    i60.enable = 1'b1; i60.up = 1'b1;
    @(negedge clock);
    i60.enable = 1'b0;
    n_cmp++; if ({i60.count, i60.wrap_flag} !== 9'h001) begin n_err++; $display("FAIL wf_set got %h want 001", {i60.count, i60.wrap_flag}); end
    load60(8'h59);
    n_cmp++; if (i60.wrap_flag !== 1'b1) begin n_err++; $display("FAIL wf_sticky got %b want 1", i60.wrap_flag); end
    i60.enable = 1'b1; i60.wrap_clear = 1'b1;
    @(negedge clock);
    i60.enable = 1'b0; i60.wrap_clear = 1'b0;
    n_cmp++; if (i60.wrap_flag !== 1'b1) begin n_err++; $display("FAIL wf_set_wins got %b want 1", i60.wrap_flag); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    {i60.enable, i60.up, i60.load, i60.load_value} = '0;
    {i24.enable, i24.up, i24.load, i24.load_value} = '0;
    {is.enable, is.up, is.load, is.load_value} = '0;
    {im.up, im.load, im.load_value} = '0;
    {ih.up, ih.load, ih.load_value} = '0;
    is.up = 1'b1; im.up = 1'b1; ih.up = 1'b1;
`ifdef BCD_MODULO_COUNTER_WRAP_FLAG_EN
    {i60.wrap_clear, i24.wrap_clear, is.wrap_clear, im.wrap_clear, ih.wrap_clear} = '0;
`endif
    repeat (2) @(negedge clock);
    reset = 1'b1;
    test_reset;
    test_up_wrap;
    test_down_wrap;
    test_load_rules;
    test_cascade;
`ifdef BCD_MODULO_COUNTER_WRAP_FLAG_EN
    test_wrap_flag;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/bcd_modulo_counter.md
Name: bcd_modulo_counter

Overview:
- Parametrised multi-digit BCD counter with programmable modulus, up/down direction, synchronous load and cascade carry/borrow.
- Successor to the fixed 00..59 time counter.
- Building block for seconds/minutes (MODULUS=60), hours (24) and day-of-month style chains in the clock/timer datapath.
- Instances cascade by wiring one stage's carry to the next stage's enable.

Parameters:
- DIGITS, 2, number of BCD digits; count width is 4*DIGITS.
- MODULUS, 60, count range 0..MODULUS-1; legal range 2..10^DIGITS. Elaboration error outside this range.
- RESET_VALUE, 0, binary value loaded on reset; must be < MODULUS.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  count-step qualifier.
- up  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous load strobe.
- load_value  input  4*DIGITS  BCD value to load.
- count  output  4*DIGITS  current BCD count, registered.
- max  output  1  count == MODULUS-1 (combinational from count).
- min  output  1  count == 0 (combinational from count).
- carry  output  1  terminal-count strobe for cascading (combinational).
- load_err  output  1  registered one-cycle pulse flagging a rejected load.

Behaviour:
- Reset (reset low, asynchronous): count = RESET_VALUE in BCD, load_err = 0. Release is synchronised by the integrator, not inside this block.
- Per-edge priority: load > enable > hold.
- load=1 with valid load_value:
  - Valid means every nibble ≤ 9 and value < MODULUS.
  - count <= load_value next edge; enable is ignored that cycle; load_err <= 0.
- load=1 with invalid load_value: count holds; load_err <= 1 for exactly one cycle.
- enable=1, up=1:
  - max=1: count <= 0.
  - Otherwise BCD increment; a digit at 9 goes to 0 and carries into the next digit.
- enable=1, up=0:
  - min=1: count <= MODULUS-1 in BCD.
  - Otherwise BCD decrement; a digit at 0 goes to 9 and borrows from the next digit.
- enable=0 and load=0: count holds; load_err <= 0.
- carry = enable & ~load & ((up & max) | (~up & min)).
  - Zero latency; asserted in the cycle before the wrap edge.
  - The downstream stage's enable samples it on the same edge.
- Direction change is honoured on the very cycle up toggles; no pipeline, no turnaround cycle.
- count is always a valid BCD value in 0..MODULUS-1; no illegal state is reachable.
- Async reset mid-count overrides load/enable immediately. The first step after release uses the inputs present at that edge.
- MODULUS = 10^DIGITS degenerates to a plain decade chain; max is then all nines.

Optional Feature:
- Macro: BCD_MODULO_COUNTER_WRAP_FLAG_EN.
- Defined:
  - Extra ports wrap_flag (output, 1) and wrap_clear (input, 1).
  - wrap_flag is sticky: set on any edge where carry=1; cleared by wrap_clear.
  - Set wins over clear in the same cycle.
  - Reset value 0.
- Undefined: ports and flop are absent; behaviour is otherwise identical.

Decomposition:
- Package bcd_pkg:
  - Constant BCD_DIGIT_W = 4; constants BCD_NINE and BCD_ZERO.
  - Function bin_to_bcd(value, DIGITS) for RESET_VALUE and MODULUS-1 conversion.
  - Function bcd_valid(vector, DIGITS).
- Sub-module bcd_digit (one per digit via generate):
  - Inputs: step, up.
  - Outputs: digit, at_nine, at_zero.
  - Ripples carry/borrow to the next digit.
- Top level holds modulus compare, load validation and wrap muxing.

Test Plan:
- Reset, MODULUS=60: hold reset low mid-count at 0x37 → count=0x00 asynchronously, before the next clock edge; load_err=0.
- Up wrap, MODULUS=60: enable=1, up=1 from 0x58 → 0x59 (max=1, carry=1 that cycle) → 0x00, with exactly one carry pulse.
- Down wrap, MODULUS=24: load 0x01, then enable, up=0 → 0x00 (min=1, carry=1) → 0x23; then 0x22.
- Load rules, MODULUS=60:
  - load 0x5A → count holds, load_err pulses one cycle.
  - load 0x60 → rejected.
  - load 0x42 with enable=1 → count=0x42, no step.
- Cascade: secs (60) → mins (60) → hours (24) chain from 23:59:59 with secs enable=1 → 00:00:00 in one edge; carries propagate combinationally.
- WRAP_FLAG_EN: wrap_flag sets on the 0x59→0x00 edge; wrap_clear asserted together with a new carry → flag stays 1.
